// File: rtl/wr_nic_top.sv
`default_nettype none
// ============================================================================
// wr_nic_top : host register-bus slave (WRPC RAM, NIC/TXTSU/DIO scratch, VIC)
// Revision   : 1.0
// ============================================================================
module wr_nic_top #(
    parameter int G_RAM_WORDS = 256,
    parameter int G_NUM_IRQS  = 4
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_n_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [19:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [G_NUM_IRQS-1:0] irq_i,
    output logic                  irq_master_o
);
    localparam int RAM_AW = $clog2(G_RAM_WORDS);

    localparam logic [3:0]  REGION_RAM   = 4'h8;
    localparam logic [3:0]  REGION_NIC   = 4'hA;
    localparam logic [3:0]  REGION_VIC   = 4'hC;
    localparam logic [3:0]  REGION_TXTSU = 4'hD;
    localparam logic [3:0]  REGION_DIO   = 4'hE;

    localparam logic [13:0] VIC_CTL  = 14'h0;
    localparam logic [13:0] VIC_IMR  = 14'h1;
    localparam logic [13:0] VIC_PEND = 14'h2;
    localparam logic [13:0] VIC_VAR  = 14'h5;
    localparam logic [13:0] VIC_SWIR = 14'h6;
    localparam logic [13:0] VIC_EOIR = 14'h7;

    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;
    logic [1:0]            ctl_q, ctl_d;
    logic [G_NUM_IRQS-1:0] imr_q, imr_d;
    logic [G_NUM_IRQS-1:0] pend_q, pend_d;
    logic [G_NUM_IRQS-1:0] irq_prev_q, irq_prev_d;
    logic                  irq_out_q, irq_out_d;
    logic [2:0][3:0][31:0] scr_q, scr_d;
    logic [31:0]           ram_q [G_RAM_WORDS];

    logic                  access;
    logic                  wr_en;
    logic                  vic_wr;
    logic [3:0]            region;
    logic [13:0]           word_off;
    logic [RAM_AW-1:0]     ram_idx;
    logic [31:0]           byte_mask;
    logic [1:0]            bank;
    logic                  bank_hit;
    logic                  scr_hit;
    logic [G_NUM_IRQS-1:0] sw_set;
    logic [G_NUM_IRQS-1:0] eoi_clr;
    logic [G_NUM_IRQS-1:0] active_lines;
    logic                  active_next;
    logic [31:0]           var_idx;
    logic                  unused_bits;

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

    // A new access is accepted only while ack is low, which enforces the idle gap.
    always_comb begin
        access   = wb_cyc_i & wb_stb_i & ~ack_q;
        wr_en    = access & wb_we_i;
        region   = wb_adr_i[19:16];
        word_off = wb_adr_i[15:2];
        ram_idx  = wb_adr_i[RAM_AW+1:2];
        for (int b = 0; b < 4; b++) begin
            byte_mask[8*b +: 8] = {8{wb_sel_i[b]}};
        end
    end

    always_comb begin
        bank     = 2'd0;
        bank_hit = 1'b1;
        case (region)
            REGION_NIC:   bank = 2'd0;
            REGION_TXTSU: bank = 2'd1;
            REGION_DIO:   bank = 2'd2;
            default:      bank_hit = 1'b0;
        endcase
        scr_hit = bank_hit & (word_off[13:2] == 12'd0);
    end

    always_comb begin
        var_idx = '0;
        for (int i = G_NUM_IRQS - 1; i >= 0; i--) begin
            if (active_lines[i]) begin
                var_idx = 32'(i);
            end
        end
    end

    always_comb begin
        vic_wr  = wr_en & (region == REGION_VIC);
        sw_set  = '0;
        eoi_clr = '0;
        ctl_d   = ctl_q;
        imr_d   = imr_q;
        if (vic_wr) begin
            case (word_off)
                VIC_CTL:  ctl_d   = wb_dat_i[1:0];
                VIC_IMR:  imr_d   = wb_dat_i[G_NUM_IRQS-1:0];
                VIC_SWIR: sw_set  = wb_dat_i[G_NUM_IRQS-1:0];
                VIC_EOIR: eoi_clr = wb_dat_i[G_NUM_IRQS-1:0];
                default:  ;
            endcase
        end
        irq_prev_d   = irq_i;
        // Set terms are OR-ed in after the clear so a same-cycle set wins.
        pend_d       = (pend_q & ~eoi_clr) | (irq_i & ~irq_prev_q) | sw_set;
        active_lines = pend_q & imr_q;
        active_next  = |(pend_d & imr_d);
        irq_out_d    = ctl_d[0] & (ctl_d[1] ? active_next : ~active_next);
    end

    always_comb begin
        scr_d = scr_q;
        if (wr_en && scr_hit) begin
            scr_d[bank][word_off[1:0]] = (scr_q[bank][word_off[1:0]] & ~byte_mask)
                                       | (wb_dat_i & byte_mask);
        end
    end

    always_comb begin
        ack_d = access;
        dat_d = '0;
        if (access && !wb_we_i) begin
            case (region)
                REGION_RAM: dat_d = ram_q[ram_idx];
                REGION_VIC: begin
                    case (word_off)
                        VIC_CTL:  dat_d[1:0]            = ctl_q;
                        VIC_IMR:  dat_d[G_NUM_IRQS-1:0] = imr_q;
                        VIC_PEND: dat_d[G_NUM_IRQS-1:0] = pend_q;
                        VIC_VAR:  dat_d                 = var_idx;
                        default:  ;
                    endcase
                end
                default: begin
                    if (scr_hit) begin
                        dat_d = scr_q[bank][word_off[1:0]];
                    end
                end
            endcase
        end
    end

    // RAM has no reset; writes are blocked while reset is held.
    always_ff @(posedge clk_sys_i) begin
        if (rst_n_i && wr_en && (region == REGION_RAM)) begin
            ram_q[ram_idx] <= (ram_q[ram_idx] & ~byte_mask) | (wb_dat_i & byte_mask);
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            ctl_q      <= '0;
            imr_q      <= '0;
            pend_q     <= '0;
            irq_prev_q <= '0;
            irq_out_q  <= 1'b0;
            scr_q      <= '0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            ctl_q      <= ctl_d;
            imr_q      <= imr_d;
            pend_q     <= pend_d;
            irq_prev_q <= irq_prev_d;
            irq_out_q  <= irq_out_d;
            scr_q      <= scr_d;
        end
    end

    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = dat_q;
    assign irq_master_o = irq_out_q;

endmodule
`default_nettype wire

// File: tb/tb_wr_nic_top.sv
`default_nettype none
// ============================================================================
// tb_wr_nic_top : randomized scoreboard bench for wr_nic_top
// Revision      : 1.0
// ============================================================================
module tb_wr_nic_top;
    logic        clk_sys_i = 1'b0;
    logic        rst_n_i   = 1'b0;
    logic        wb_cyc_i  = 1'b0;
    logic        wb_stb_i  = 1'b0;
    logic        wb_we_i   = 1'b0;
    logic [3:0]  wb_sel_i  = 4'h0;
    logic [19:0] wb_adr_i  = '0;
    logic [31:0] wb_dat_i  = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [3:0]  irq_i     = 4'h0;
    logic        irq_master_o;

    wr_nic_top #(.G_RAM_WORDS(256), .G_NUM_IRQS(4)) dut (
        .clk_sys_i    (clk_sys_i),
        .rst_n_i      (rst_n_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_stb_i     (wb_stb_i),
        .wb_we_i      (wb_we_i),
        .wb_sel_i     (wb_sel_i),
        .wb_adr_i     (wb_adr_i),
        .wb_dat_i     (wb_dat_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o),
        .irq_i        (irq_i),
        .irq_master_o (irq_master_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    typedef struct {
        bit        rd;
        bit [19:0] adr;
        bit [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    bit [31:0] m_ram [256];
    bit [31:0] m_scr [3][4];
    bit [1:0]  m_ctl;
    bit [3:0]  m_imr;
    bit [3:0]  m_pend;
    bit [3:0]  irq_drv;

    function automatic void model_reset();
        m_ctl  = 0;
        m_imr  = 0;
        m_pend = 0;
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < 4; r++) m_scr[b][r] = 0;
    endfunction

    function automatic int bank_of(bit [3:0] region);
        case (region)
            4'hA:    return 0;
            4'hD:    return 1;
            4'hE:    return 2;
            default: return -1;
        endcase
    endfunction

    function automatic bit [31:0] lowest_active();
        for (int i = 0; i < 4; i++) if (m_pend[i] && m_imr[i]) return i;
        return 0;
    endfunction

    function automatic bit [31:0] model_read(bit [19:0] a);
        bit [15:0] off = {a[15:2], 2'b00};
        int        b   = bank_of(a[19:16]);
        if (a[19:16] == 4'h8) return m_ram[a[9:2]];
        if (a[19:16] == 4'hC) begin
            case (off)
                16'h00:  return {30'd0, m_ctl};
                16'h04:  return {28'd0, m_imr};
                16'h08:  return {28'd0, m_pend};
                16'h14:  return lowest_active();
                default: return 0;
            endcase
        end
        if (b >= 0 && off < 16'h10) return m_scr[b][off[3:2]];
        return 0;
    endfunction

    function automatic void model_write(bit [19:0] a, bit [31:0] d, bit [3:0] sel);
        bit [15:0] off = {a[15:2], 2'b00};
        int        b   = bank_of(a[19:16]);
        bit [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
        if (a[19:16] == 4'h8) begin
            m_ram[a[9:2]] = (m_ram[a[9:2]] & ~m) | (d & m);
        end else if (a[19:16] == 4'hC) begin
            case (off)
                16'h00:  m_ctl  = d[1:0];
                16'h04:  m_imr  = d[3:0];
                16'h18:  m_pend = m_pend | d[3:0];
                16'h1C:  m_pend = m_pend & ~d[3:0];
                default: ;
            endcase
        end else if (b >= 0 && off < 16'h10) begin
            m_scr[b][off[3:2]] = (m_scr[b][off[3:2]] & ~m) | (d & m);
        end
    endfunction

    function automatic bit model_irq();
        bit act = |(m_pend & m_imr);
        if (!m_ctl[0]) return 1'b0;
        return m_ctl[1] ? act : ~act;
    endfunction

    // Called at posedge+1; issues one transfer and waits for its ack.
    task automatic bus_xfer(input bit we, input bit [19:0] a, input bit [31:0] d,
                            input bit [3:0] sel);
        exp_t e;
        int   n = 0;
        e.rd  = !we;
        e.adr = a;
        e.dat = we ? 32'd0 : model_read(a);
        if (we) model_write(a, d, sel);
        sb_q.push_back(e);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
        wb_adr_i = a; wb_dat_i = d; wb_sel_i = sel;
        do begin
            @(posedge clk_sys_i); #1;
            n++;
        end while (!wb_ack_o && n < 8);
        if (!wb_ack_o) begin
            tests++; fails++;
            $display("FAIL ack_timeout adr=%05h got ack=0 want ack=1", a);
            void'(sb_q.pop_back());
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        @(posedge clk_sys_i); #1;
    endtask

    task automatic wr(input bit [19:0] a, input bit [31:0] d, input bit [3:0] sel = 4'hF);
        bus_xfer(1'b1, a, d, sel);
    endtask

    task automatic rd(input bit [19:0] a);
        bus_xfer(1'b0, a, 32'd0, 4'hF);
    endtask

    task automatic set_irq(input bit [3:0] v);
        m_pend  = m_pend | (v & ~irq_drv);
        irq_drv = v;
        irq_i   = v;
        repeat (2) @(posedge clk_sys_i);
        #1;
    endtask

    task automatic check_irq(input string name);
        bit want = model_irq();
        int n    = 0;
        while (irq_master_o !== want && n < 3) begin
            @(posedge clk_sys_i); #1;
            n++;
        end
        tests++;
        if (irq_master_o !== want) begin
            fails++;
            $display("FAIL irq_%s got %0b want %0b", name, irq_master_o, want);
        end
    endtask

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %08h want %08h", name, got, want);
        end
    endtask

    // Monitor: every ack pops one expectation; reads also compare data.
    initial begin : monitor
        bit   prev_ack = 0;
        exp_t e;
        forever begin
            @(negedge clk_sys_i);
            if (wb_ack_o) begin
                tests++;
                if (prev_ack) begin
                    fails++;
                    $display("FAIL ack_pulse ack high two cycles, want single-cycle pulse");
                end
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ack got ack=1 want no ack");
                end else begin
                    e = sb_q.pop_front();
                    if (e.rd) begin
                        tests++;
                        if (wb_dat_o !== e.dat) begin
                            fails++;
                            $display("FAIL rd_data adr=%05h got %08h want %08h",
                                     e.adr, wb_dat_o, e.dat);
                        end
                    end
                end
            end
            prev_ack = wb_ack_o;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit [19:0] a;
        bit [15:0] vic_offs [8] = '{16'h00, 16'h04, 16'h08, 16'h14, 16'h18, 16'h1C, 16'h10, 16'h20};
        bit [3:0]  unmapped [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hF};
        bit [3:0]  scr_reg  [3] = '{4'hA, 4'hD, 4'hE};
        int        n;

        model_reset();
        irq_drv = 0;
        repeat (3) @(posedge clk_sys_i);
        #1;
        check_now("reset_ack", {31'd0, wb_ack_o}, 32'd0);
        check_now("reset_dat", wb_dat_o, 32'd0);
        check_now("reset_irq", {31'd0, irq_master_o}, 32'd0);
        rst_n_i = 1;
        @(posedge clk_sys_i); #1;

        // RAM write/read-back
        wr(20'h80100, 32'hDEADBEEF);
        wr(20'h80104, 32'hCAFEBABE);
        rd(20'h80100);
        rd(20'h80104);

        // Software interrupt, active-high polarity
        wr(20'hC0004, 32'h1);
        wr(20'hC0000, 32'h3);
        wr(20'hC0018, 32'h1);
        check_irq("swir_set");
        rd(20'hC0008);
        rd(20'hC0014);
        wr(20'hC001C, 32'h1);
        check_irq("eoir_clr");

        // Active-low polarity, external edge on line 2
        wr(20'hC0000, 32'h1);
        wr(20'hC0004, 32'h4);
        check_irq("pol_low_idle");
        set_irq(4'h4);
        set_irq(4'h0);
        check_irq("pol_low_line2");
        rd(20'hC0014);
        set_irq(4'h2);
        check_irq("masked_line1");
        rd(20'hC0008);
        set_irq(4'h0);

        // Rising edge coinciding with EOIR of the same bit: set wins
        irq_i = 4'h1;
        wr(20'hC001C, 32'h1);
        m_pend  = m_pend | 4'h1;
        irq_drv = 4'h1;
        rd(20'hC0008);
        set_irq(4'h0);
        wr(20'hC001C, 32'hF);
        check_irq("after_eoir_all");

        // Byte enables on DIO scratch and unmapped region
        wr(20'hE0004, 32'hFFFFFFFF);
        wr(20'hE0004, 32'h11223344, 4'b0011);
        rd(20'hE0004);
        rd(20'hF0000);

        // Random traffic
        for (int k = 0; k < 16; k++) wr(20'h80000 | (k << 2), $urandom);
        for (int it = 0; it < 160; it++) begin
            case ($urandom_range(0, 3))
                0: a = {4'h8, 6'($urandom), 4'd0, 4'($urandom_range(0, 15)), 2'b00};
                1: a = {4'hC, vic_offs[$urandom_range(0, 7)]};
                2: a = {scr_reg[$urandom_range(0, 2)], 11'd0, 5'($urandom_range(0, 7) << 2)};
                default: a = {unmapped[$urandom_range(0, 9)], 16'($urandom)};
            endcase
            bus_xfer(1'($urandom), a, $urandom, 4'($urandom));
            if ($urandom_range(0, 3) == 0) set_irq(4'($urandom));
            if ($urandom_range(0, 3) == 0) check_irq("random");
        end

        // Reset asserted during a read
        wr(20'hC0004, 32'hF);
        wr(20'hC0000, 32'h1);
        wr(20'hA0008, 32'h12345678);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 20'hC0000;
        #2;
        rst_n_i = 0;
        #1;
        check_now("midreset_ack", {31'd0, wb_ack_o}, 32'd0);
        check_now("midreset_irq", {31'd0, irq_master_o}, 32'd0);
        wb_cyc_i = 0; wb_stb_i = 0;
        irq_i = 0; irq_drv = 0;
        model_reset();
        repeat (2) @(posedge clk_sys_i);
        #1;
        rst_n_i = 1;
        @(posedge clk_sys_i); #1;
        check_irq("after_reset");
        rd(20'hC0000);
        rd(20'hC0004);
        rd(20'hC0008);
        rd(20'hC0014);
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < 4; r++) rd({scr_reg[b], 12'd0, 2'(r), 2'b00});

        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(posedge clk_sys_i);
            n++;
        end
        if (sb_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
